// File: rtl/pupil_pkg.sv
// Shared types and constants for the pupil locator.
// Holds the FSM state enum, pixel/coordinate widths and default frame geometry.
package pupil_pkg;

    localparam int PIX_W   = 10;
    localparam int COORD_W = 10;

    localparam int DEF_IMG_W     = 640;
    localparam int DEF_IMG_H     = 480;
    localparam int DEF_MIN_COUNT = 64;
    localparam int DEF_SUM_W     = 28;
    localparam int DEF_CNT_W     = 19;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DIV_X,
        DIV_Y,
        DONE
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, DVD_W clocks per divide.
// Ports: iCLK, iRST (async, active-high), iStart (pulse), iDividend, iDivisor,
//        oDone (one-cycle pulse, quotient final), oQuotient (held until next start).
module seq_divider #(
    parameter int DVD_W = 28,
    parameter int DVR_W = 19
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [DVD_W-1:0] iDividend,
    input  logic [DVR_W-1:0] iDivisor,
    output logic             oDone,
    output logic [DVD_W-1:0] oQuotient
);

    localparam int CW = $clog2(DVD_W + 1);

    logic [DVR_W-1:0] rem;
    logic [DVD_W-1:0] quo;
    logic [DVR_W-1:0] dvr;
    logic [CW-1:0]    cnt;
    logic             busy;

    logic [DVR_W-1:0] remIn;
    logic [DVD_W-1:0] quoIn;
    logic [DVR_W-1:0] dvrIn;
    logic [DVR_W:0]   shifted;
    logic             ge;
    logic [DVR_W-1:0] remNext;
    logic [DVD_W-1:0] quoNext;

    // The start cycle already performs the first iteration on the fresh
    // operands, so a divide finishes exactly DVD_W edges after start.
    always_comb begin
        remIn   = iStart ? '0 : rem;
        quoIn   = iStart ? iDividend : quo;
        dvrIn   = iStart ? iDivisor : dvr;
        shifted = {remIn, quoIn[DVD_W-1]};
        ge      = shifted >= {1'b0, dvrIn};
        // Remainder always stays below the divisor, so the top bit is zero.
        remNext = DVR_W'(ge ? (shifted - {1'b0, dvrIn}) : shifted);
        quoNext = {quoIn[DVD_W-2:0], ge};
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rem   <= '0;
            quo   <= '0;
            dvr   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            oDone <= 1'b0;
        end else begin
            oDone <= 1'b0;
            if (iStart) begin
                rem  <= remNext;
                quo  <= quoNext;
                dvr  <= iDivisor;
                cnt  <= CW'(DVD_W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= remNext;
                quo <= quoNext;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy  <= 1'b0;
                    oDone <= 1'b1;
                end
            end
        end
    end

    assign oQuotient = quo;

endmodule

// File: rtl/pupil_locator.sv
// Dark-pixel centroid finder over one raster frame; result held until next frame.
// Ports: iCLK, iRST (async high), iSOF, iDVAL, iDATA, iTHRESH in;
//        oX, oY, oFOUND, oVALID, oBUSY, oDROP out.
// Define PUPIL_BBOX_EN to add oXMIN/oXMAX/oYMIN/oYMAX bounding-box outputs.
module pupil_locator
    import pupil_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int MIN_COUNT = DEF_MIN_COUNT,
    parameter int SUM_W     = DEF_SUM_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iSOF,
    input  logic               iDVAL,
    input  logic [PIX_W-1:0]   iDATA,
    input  logic [PIX_W-1:0]   iTHRESH,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic               oFOUND,
    output logic               oVALID,
    output logic               oBUSY,
    output logic               oDROP
`ifdef PUPIL_BBOX_EN
    ,
    output logic [COORD_W-1:0] oXMIN,
    output logic [COORD_W-1:0] oXMAX,
    output logic [COORD_W-1:0] oYMIN,
    output logic [COORD_W-1:0] oYMAX
`endif
);

    localparam logic [COORD_W-1:0] XLAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] YLAST = COORD_W'(IMG_H - 1);

    state_t             state;
    logic [COORD_W-1:0] x, y;
    logic [CNT_W-1:0]   count;
    logic [SUM_W-1:0]   sumX, sumY;
    logic [PIX_W-1:0]   thr;
    logic               divStart;
    logic               divided;
    logic [COORD_W-1:0] qX;

`ifdef PUPIL_BBOX_EN
    logic [COORD_W-1:0] xMin, xMax, yMin, yMax;
`endif

    logic               dark;
    logic               lastPix;
    logic [CNT_W-1:0]   countNext;
    logic               divGo;
    logic [SUM_W-1:0]   divDvd;
    logic               divDone;
    logic [SUM_W-1:0]   divQuo;

    assign dark      = iDATA < thr;
    assign lastPix   = (x == XLAST) && (y == YLAST);
    assign countNext = count + CNT_W'(dark);
    assign oBUSY     = (state != IDLE);

    // Y division is kicked off on the same edge that captures the X
    // quotient, so no idle cycle sits between the two divides.
    assign divGo  = divStart | ((state == DIV_X) && divDone);
    assign divDvd = ((state == DIV_X) && !divDone) ? sumX : sumY;

    seq_divider #(
        .DVD_W(SUM_W),
        .DVR_W(CNT_W)
    ) uDiv (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iStart   (divGo),
        .iDividend(divDvd),
        .iDivisor (count),
        .oDone    (divDone),
        .oQuotient(divQuo)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            count    <= '0;
            sumX     <= '0;
            sumY     <= '0;
            thr      <= '0;
            divStart <= 1'b0;
            divided  <= 1'b0;
            qX       <= '0;
            oX       <= '0;
            oY       <= '0;
            oFOUND   <= 1'b0;
            oVALID   <= 1'b0;
            oDROP    <= 1'b0;
`ifdef PUPIL_BBOX_EN
            xMin  <= XLAST;
            xMax  <= '0;
            yMin  <= YLAST;
            yMax  <= '0;
            oXMIN <= '0;
            oXMAX <= '0;
            oYMIN <= '0;
            oYMAX <= '0;
`endif
        end else begin
            oVALID   <= 1'b0;
            oDROP    <= 1'b0;
            divStart <= 1'b0;
            unique case (state)
                IDLE, ACCUM: begin
                    // SOF while accumulating simply restarts the frame.
                    if (iSOF) begin
                        state <= ACCUM;
                        x     <= '0;
                        y     <= '0;
                        count <= '0;
                        sumX  <= '0;
                        sumY  <= '0;
                        thr   <= iTHRESH;
`ifdef PUPIL_BBOX_EN
                        xMin <= XLAST;
                        xMax <= '0;
                        yMin <= YLAST;
                        yMax <= '0;
`endif
                    end else if (state == ACCUM && iDVAL) begin
                        if (dark) begin
                            count <= countNext;
                            sumX  <= sumX + SUM_W'(x);
                            sumY  <= sumY + SUM_W'(y);
`ifdef PUPIL_BBOX_EN
                            if (x < xMin) xMin <= x;
                            if (x > xMax) xMax <= x;
                            if (y < yMin) yMin <= y;
                            if (y > yMax) yMax <= y;
`endif
                        end
                        if (lastPix) begin
                            x <= '0;
                            y <= '0;
                            if (countNext >= CNT_W'(MIN_COUNT)) begin
                                state    <= DIV_X;
                                divStart <= 1'b1;
                                divided  <= 1'b1;
                            end else begin
                                state   <= DONE;
                                divided <= 1'b0;
                            end
                        end else if (x == XLAST) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                DIV_X: begin
                    oDROP <= iSOF;
                    if (divDone) begin
                        qX    <= COORD_W'(divQuo);
                        state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    oDROP <= iSOF;
                    if (divDone) state <= DONE;
                end
                DONE: begin
                    // The divider still holds the Y quotient here.
                    oDROP  <= iSOF;
                    oVALID <= 1'b1;
                    oFOUND <= divided;
                    oX     <= divided ? qX : '0;
                    oY     <= divided ? COORD_W'(divQuo) : '0;
`ifdef PUPIL_BBOX_EN
                    oXMIN <= divided ? xMin : '0;
                    oXMAX <= divided ? xMax : '0;
                    oYMIN <= divided ? yMin : '0;
                    oYMAX <= divided ? yMax : '0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pupil_locator.md
Name: pupil_locator

Overview:
- Consumes the 10-bit grayscale pixel stream from the RGB-to-gray stage, one pixel per valid cycle in raster order.
- Thresholds each pixel to dark / not-dark.
- Accumulates the dark-pixel count and coordinate sums over one frame.
- After the last pixel, computes the integer centroid (pupil centre) with a shared sequential divider and presents it for one frame period.

Parameters:
- IMG_W, 640: pixels per line.
- IMG_H, 480: lines per frame.
- MIN_COUNT, 64: minimum dark-pixel count for a valid detection; must be ≥1.
- SUM_W, 28: width of the coordinate-sum accumulators; must hold IMG_W*IMG_H*(max(IMG_W,IMG_H)-1).
- CNT_W, 19: width of the dark-pixel counter; must hold IMG_W*IMG_H.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  reset: asynchronous, active-high.
- iSOF  in  1  start-of-frame pulse, one cycle, before the first pixel of a frame.
- iDVAL  in  1  iDATA valid.
- iDATA  in  10  grayscale pixel.
- iTHRESH  in  10  dark threshold, sampled at iSOF.
- oX  out  10  centroid column.
- oY  out  10  centroid row.
- oFOUND  out  1  the held result is a valid detection.
- oVALID  out  1  one-cycle pulse: oX/oY/oFOUND updated.
- oBUSY  out  1  accumulating or dividing.
- oDROP  out  1  one-cycle pulse: frame ignored because the block was busy.

Behaviour:
- Reset (async, iRST=1): oX=0, oY=0, oFOUND=0, oVALID=0, oBUSY=0, oDROP=0; all counters and accumulators 0; state IDLE.
- States: IDLE, ACCUM, DIV_X, DIV_Y, DONE.
- IDLE:
  - iSOF=1 → ACCUM; clear x, y, count, sum_x, sum_y; latch iTHRESH.
  - iDVAL without a preceding iSOF is ignored.
- ACCUM:
  - Each iDVAL pixel is dark if iDATA < latched threshold (strict).
  - Dark pixel: count+=1, sum_x+=x, sum_y+=y.
  - x increments per valid pixel; at IMG_W-1, x wraps to 0 and y increments.
  - The pixel at x=IMG_W-1, y=IMG_H-1 is accumulated, then the next state is DIV_X if count ≥ MIN_COUNT, else DONE.
  - iSOF in ACCUM restarts the frame: clear and re-latch, no oDROP.
- DIV_X: sub-module computes sum_x / count, restoring, 1 quotient bit per cycle, SUM_W cycles; quotient truncated to 10 bits → DIV_Y.
- DIV_Y: same computation for sum_y → DONE.
- DONE (1 cycle):
  - oVALID=1.
  - If divided: oX/oY = quotients, oFOUND=1.
  - Else: oX=oY=0, oFOUND=0.
  - → IDLE.
- Latency from last pixel's accept edge to oVALID:
  - 2*SUM_W+2 cycles when found (58 at defaults).
  - 1 cycle when not found.
- oBUSY=1 in ACCUM, DIV_X, DIV_Y, DONE.
- iSOF in DIV_X/DIV_Y/DONE: that frame is ignored entirely, oDROP pulses the cycle after iSOF, and pixels are discarded until the next iSOF seen in IDLE.
- Outputs oX/oY/oFOUND hold between oVALID pulses.
- Asserting iRST mid-frame or mid-division aborts immediately to reset values; no oVALID.
- Accumulator overflow cannot occur given the parameter constraints; no saturation logic.

Optional Feature:
- Macro PUPIL_BBOX_EN.
- Defined: adds outputs oXMIN, oXMAX, oYMIN, oYMAX (10 bits each), tracking the extremes of dark-pixel coordinates.
  - Reset values: min registers IMG_W-1 / IMG_H-1, max registers 0; the same values are reloaded at iSOF.
  - Bounding-box outputs update on the same oVALID; all are 0 when oFOUND=0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package pupil_pkg holds:
  - state enum (IDLE, ACCUM, DIV_X, DIV_Y, DONE);
  - PIX_W=10, COORD_W=10;
  - default IMG_W/IMG_H/SUM_W/CNT_W constants.
- Sub-module seq_divider, parameterised on dividend and divisor widths:
  - interface: start, done, quotient;
  - instantiated once and reused sequentially for X then Y.

Test Plan:
- 8x4 frame (IMG_W=8, IMG_H=4, MIN_COUNT=1), iTHRESH=100, dark pixels (value 10) at (2,1),(3,1),(2,2),(3,2) → oVALID once, oX=2, oY=1, oFOUND=1, exactly 2*SUM_W+2 cycles after the last pixel.
- All pixels 1023 → count 0 < MIN_COUNT → oFOUND=0, oX=oY=0, oVALID 1 cycle after the last pixel.
- Pixel equal to threshold (100 with iTHRESH=100) → not counted; a value of 99 is counted.
- iSOF asserted during DIV_X → oDROP pulse, following pixels ignored; current result still completes correctly.
- iRST pulse mid-ACCUM, then a full clean frame → no oVALID from the aborted frame; correct centroid for the clean frame.
- With PUPIL_BBOX_EN and the first frame's pixels → oXMIN=2, oXMAX=3, oYMIN=1, oYMAX=2.
